ctrl_loop_seq: RTL
==================

# ctrl_loop_seq

Nested-loop index sequencer that consumes the per-layer loop bounds (KSI, CKG, L0..L4) produced by the NPU control parameter block and walks the full iteration space, one index tuple per accepted beat. It sits between the control-parameter logic and the datapath address generators. It latches bounds on a start handshake and streams index tuples under valid/ready backpressure. It signals completion with a one-cycle done pulse.

## Interface
- CLOG2K, default 3: width of the KSI bound/index.
- CLOG2W, default 6: width of the CKG bound/index.
- CLOG2L, default 6: width of the L0..L4 bounds/indices.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request to begin a sequence.
- start_ready  out  1  high only in IDLE; start is accepted when start&start_ready.
- abort  in  1  synchronous abort; returns to IDLE, no done.
- arv_KSI  in  CLOG2K  inclusive max KSI index (count = value+1).
- arv_CKG  in  CLOG2W  inclusive max CKG index.
- arv_L0..arv_L4  in  CLOG2L each  inclusive max of loop levels L0..L4.
- out_valid  out  1  index tuple valid.
- out_ready  in  1  consumer accepts the tuple.
- idx_KSI  out  CLOG2K  current KSI index.
- idx_CKG  out  CLOG2W  current CKG index.
- idx_L0..idx_L4  out  CLOG2L each  current loop indices.
- out_last  out  7  bit i is set when levels 0..i are all at their max. Bit order: 0=KSI, 1=CKG, 2=L0 … 6=L4. Bit 6 marks the final beat.
- done  out  1  one-cycle pulse after the final beat is accepted.
- stall_cnt  out  32  backpressure stall count. Only meaningful with the configuration macro.

## Operation
- States:
  - IDLE: start_ready=1, out_valid=0.
  - RUN: out_valid=1.
- IDLE→RUN on start&start_ready.
  - All seven arv_* inputs are latched into internal bound registers.
  - All indices are cleared to 0.
  - Later changes on arv_* have no effect until the next start.
- In RUN, each beat (out_valid&out_ready) advances the odometer:
  - KSI increments.
  - When KSI equals its latched bound it wraps to 0 and CKG increments, and so on outward through L0, L1, L2, L3, L4.
  - Each level compares against its own latched bound. Wrap is by equality, never by width overflow.
- out_last is combinational from the current indices vs the latched bounds.
  - out_last[i] = AND over levels 0..i of (idx == bound).
- RUN→IDLE on a beat with out_last[6]=1. done=1 in the following cycle, which is an IDLE cycle.
- Total beats = product over the seven levels of (bound+1).
  - All-zero bounds give exactly 1 beat.
  - All bounds at max width value give 2^(CLOG2K+CLOG2W+5·CLOG2L) beats with no overflow.
- abort:
  - Highest priority over start and beats in the same cycle.
  - Next state is IDLE, indices cleared, done not pulsed.
  - In IDLE it has no effect, and a simultaneous start is dropped.
- No beat occurs while out_ready=0. Indices and out_last hold stable while out_valid&!out_ready.

## Timing
- Reset values:
  - state IDLE, start_ready=1, out_valid=0, done=0, out_last=0.
  - All idx_*=0, latched bounds=0, stall_cnt=0.
- Start accepted at edge t: out_valid=1 with all indices 0 from cycle t+1. Latency is 1 cycle.
- Throughput is 1 beat/cycle when out_ready is held high.
- Final beat at edge n:
  - cycle n+1 has out_valid=0, done=1, start_ready=1.
  - A start in cycle n+1 is accepted, giving out_valid=1 at n+2.
  - Minimum gap between sequences is 1 idle cycle.
- done is never high for two consecutive cycles.
- Reset asserted mid-RUN forces the reset values immediately (asynchronous). No done is produced.

## Configuration
- CTRL_LOOP_STALL_CNT_EN defined:
  - stall_cnt counts cycles with out_valid=1 and out_ready=0.
  - It clears to 0 on start acceptance and holds its value after RUN ends, until the next start.
  - It saturates at 2^32-1.
- Undefined: stall_cnt is constant 0 and no counter logic is instantiated. The port remains, so the interface is unchanged.

## Test plan
- Minimal sequence: all bounds 0, start, out_ready=1.
  - Exactly 1 beat with all idx=0 and out_last=7'h7F.
  - done is high exactly one cycle later.
- Odometer order: arv_KSI=1, arv_CKG=2, L0..L4=0, out_ready=1.
  - 6 beats with (KSI,CKG) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
  - out_last[0] is high on odd beats; out_last[6] is high only on the last beat.
- Backpressure: arv_KSI=3, others 0, out_ready toggling 1,0,0,1,…
  - The index holds during low cycles; 4 beats total.
  - With CTRL_LOOP_STALL_CNT_EN, stall_cnt equals the number of low cycles while valid.
- Bound latching: start with arv_L0=2, change arv_L0 to 5 on the next cycle.
  - The sequence still produces 3 L0 values.
- Abort and reset:
  - abort in the 3rd RUN cycle gives out_valid=0 the next cycle, no done, start_ready=1.
  - rst asserted mid-RUN asynchronously returns all outputs to their reset values.
- Back-to-back: start asserted in the done cycle.
  - The new sequence begins with idx=0 two cycles after the final beat.

Source files
------------

// File: rtl/ctrl_loop_seq.sv
// ctrl_loop_seq: nested-loop index sequencer.
// It latches the seven inclusive loop bounds (KSI, CKG, L0..L4) when a start is
// accepted. It then emits one index tuple per accepted beat, with KSI as the
// innermost level. A one-cycle done pulse follows the final beat.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start / start_ready  sequence request handshake; start_ready is high only in IDLE
//   abort                synchronous abort back to IDLE, with no done pulse
//   arv_*                inclusive max index per level, latched when start is accepted
//   out_valid/out_ready  index tuple handshake
//   idx_*                current index tuple
//   out_last             bit i is set when levels 0..i are all at their bound
//   done                 one-cycle pulse after the final beat
//   stall_cnt            backpressure stall counter
//
// Optional feature: define CTRL_LOOP_STALL_CNT_EN to build the stall counter.
// Without it, stall_cnt is tied to 0.
module ctrl_loop_seq #(
    parameter int unsigned CLOG2K = 3,
    parameter int unsigned CLOG2W = 6,
    parameter int unsigned CLOG2L = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              start_ready,
    input  logic              abort,
    input  logic [CLOG2K-1:0] arv_KSI,
    input  logic [CLOG2W-1:0] arv_CKG,
    input  logic [CLOG2L-1:0] arv_L0,
    input  logic [CLOG2L-1:0] arv_L1,
    input  logic [CLOG2L-1:0] arv_L2,
    input  logic [CLOG2L-1:0] arv_L3,
    input  logic [CLOG2L-1:0] arv_L4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLOG2K-1:0] idx_KSI,
    output logic [CLOG2W-1:0] idx_CKG,
    output logic [CLOG2L-1:0] idx_L0,
    output logic [CLOG2L-1:0] idx_L1,
    output logic [CLOG2L-1:0] idx_L2,
    output logic [CLOG2L-1:0] idx_L3,
    output logic [CLOG2L-1:0] idx_L4,
    output logic [6:0]        out_last,
    output logic              done,
    output logic [31:0]       stall_cnt
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t            state_q;
    logic              start_ready_q;
    logic              out_valid_q;
    logic              done_q;
    logic [CLOG2K-1:0] idx_ksi_q, bnd_ksi_q;
    logic [CLOG2W-1:0] idx_ckg_q, bnd_ckg_q;
    logic [CLOG2L-1:0] idx_l_q [5];
    logic [CLOG2L-1:0] bnd_l_q [5];
    logic [6:0]        eq_c;
    logic [6:0]        last_c;
    logic              start_acc_c;

    assign start_acc_c = start && start_ready_q && !abort;

    // Per-level "at bound" flags, then a running AND from the innermost level outward.
    always_comb begin
        eq_c[0] = (idx_ksi_q == bnd_ksi_q);
        eq_c[1] = (idx_ckg_q == bnd_ckg_q);
        for (int l = 0; l < 5; l++) begin
            eq_c[l+2] = (idx_l_q[l] == bnd_l_q[l]);
        end
        last_c[0] = eq_c[0];
        for (int i = 1; i < 7; i++) begin
            last_c[i] = last_c[i-1] & eq_c[i];
        end
    end

    // Sequencer FSM. The odometer is a carry chain: a level steps only when
    // every level inside it has wrapped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            start_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            idx_ksi_q     <= '0;
            idx_ckg_q     <= '0;
            bnd_ksi_q     <= '0;
            bnd_ckg_q     <= '0;
            for (int l = 0; l < 5; l++) begin
                idx_l_q[l] <= '0;
                bnd_l_q[l] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q       <= ST_IDLE;
                start_ready_q <= 1'b1;
                out_valid_q   <= 1'b0;
                idx_ksi_q     <= '0;
                idx_ckg_q     <= '0;
                for (int l = 0; l < 5; l++) idx_l_q[l] <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q       <= ST_RUN;
                            start_ready_q <= 1'b0;
                            out_valid_q   <= 1'b1;
                            bnd_ksi_q     <= arv_KSI;
                            bnd_ckg_q     <= arv_CKG;
                            bnd_l_q[0]    <= arv_L0;
                            bnd_l_q[1]    <= arv_L1;
                            bnd_l_q[2]    <= arv_L2;
                            bnd_l_q[3]    <= arv_L3;
                            bnd_l_q[4]    <= arv_L4;
                            idx_ksi_q     <= '0;
                            idx_ckg_q     <= '0;
                            for (int l = 0; l < 5; l++) idx_l_q[l] <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (out_ready) begin
                            if (last_c[6]) begin
                                state_q       <= ST_IDLE;
                                start_ready_q <= 1'b1;
                                out_valid_q   <= 1'b0;
                                done_q        <= 1'b1;
                                idx_ksi_q     <= '0;
                                idx_ckg_q     <= '0;
                                for (int l = 0; l < 5; l++) idx_l_q[l] <= '0;
                            end else begin
                                idx_ksi_q <= last_c[0] ? '0 : idx_ksi_q + CLOG2K'(1);
                                if (last_c[0]) begin
                                    idx_ckg_q <= last_c[1] ? '0 : idx_ckg_q + CLOG2W'(1);
                                end
                                for (int l = 0; l < 5; l++) begin
                                    if (last_c[l+1]) begin
                                        idx_l_q[l] <= last_c[l+2] ? '0 : idx_l_q[l] + CLOG2L'(1);
                                    end
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef CTRL_LOOP_STALL_CNT_EN
    logic [31:0] stall_q;

    // Counts valid-but-not-ready cycles. It saturates, and it holds its value
    // after RUN ends until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_acc_c) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc_c;
    assign stall_cnt        = 32'd0;
`endif

    assign start_ready = start_ready_q;
    assign out_valid   = out_valid_q;
    assign done        = done_q;
    assign idx_KSI     = idx_ksi_q;
    assign idx_CKG     = idx_ckg_q;
    assign idx_L0      = idx_l_q[0];
    assign idx_L1      = idx_l_q[1];
    assign idx_L2      = idx_l_q[2];
    assign idx_L3      = idx_l_q[3];
    assign idx_L4      = idx_l_q[4];
    // Gated with out_valid so that IDLE (with bounds at 0) reports no last flags.
    assign out_last    = out_valid_q ? last_c : 7'h00;

endmodule
